uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver.
- Each `rx_done_tick` pulse captures `rx_dout` into a circular FIFO.
- Presents buffered bytes to the consumer (CPU or bus bridge) over a valid/ready read port, with a first-word-fall-through (show-ahead) head.
- Reports occupancy, an almost-full level and a sticky overrun flag, so software can read bytes at its own pace without losing frames.

---
 rtl/uart_rx_fifo_if.sv | 37 +++
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- byte-stream handshake around the receive FIFO.
//
// Carries both sides of the data path through the buffer:
//   rx_done_tick  1     write strobe from the UART receiver
//   rx_dout       DBIT  received byte, valid with rx_done_tick
//   rd_ready      1     consumer accepts the head word
//   rd_data       DBIT  head word (first-word-fall-through)
//   rd_valid      1     head word present (FIFO non-empty)
//
// master: the environment (receiver + consumer) that drives strobes/ready.
// slave : the FIFO that returns the head word and its valid flag.

interface uart_rx_fifo_if #(
   parameter int unsigned DBIT = 8
);
   logic            rx_done_tick;
   logic [DBIT-1:0] rx_dout;
   logic            rd_ready;
   logic [DBIT-1:0] rd_data;
   logic            rd_valid;

   modport master (
      output rx_done_tick,
      output rx_dout,
      output rd_ready,
      input  rd_data,
      input  rd_valid
   );

   modport slave (
      input  rx_done_tick,
      input  rx_dout,
      input  rd_ready,
      output rd_data,
      output rd_valid
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- circular receive buffer behind a UART receiver.
//
// Every rx_done_tick stores rx_dout; the oldest stored byte is always shown
// on rd_data (show-ahead) and leaves the buffer when rd_valid & rd_ready.
// A write arriving while full is accepted only if a read frees a slot in
// the same cycle; otherwise it is dropped and the sticky overrun flag set.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          handshake interface (slave side), see uart_rx_fifo_if
//   clr_overrun  one-cycle pulse clearing overrun (a same-cycle drop wins)
//   full         count == 2**ADDR_W
//   almost_full  count >= AF_LEVEL (AF_LEVEL in 1..2**ADDR_W)
//   count        stored words, 0..2**ADDR_W
//   overrun      sticky: a byte was dropped because the FIFO was full

module uart_rx_fifo #(
   parameter int unsigned DBIT     = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   uart_rx_fifo_if.slave     bus,
   input  logic              clr_overrun,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overrun
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] ptr_t;
   typedef logic [ADDR_W:0]   cnt_t;

   localparam ptr_t PTR_ONE = ptr_t'(1);
   localparam cnt_t CNT_ONE = cnt_t'(1);
   localparam cnt_t CNT_MAX = cnt_t'(DEPTH);
   localparam cnt_t CNT_AF  = cnt_t'(AF_LEVEL);

   logic [DBIT-1:0] mem [DEPTH];
   ptr_t            wr_ptr;
   ptr_t            rd_ptr;

   logic rd_fire;
   logic wr;
   logic drop;

   // Status flags decode the registered count only, so they follow the
   // causing event by one cycle and clear immediately on async reset.
   assign bus.rd_valid = (count != '0);
   assign full         = (count == CNT_MAX);
   assign almost_full  = (count >= CNT_AF);
   assign bus.rd_data  = mem[rd_ptr];

   assign rd_fire = bus.rd_valid & bus.rd_ready;
   // A read in the same cycle frees the slot, so a write while full is
   // still accepted in that case.
   assign wr      = bus.rx_done_tick & (~full | rd_fire);
   assign drop    = bus.rx_done_tick & ~wr;

   // NOTE: storage has no reset; contents are unobservable until written
   // because rd_valid depends on count, which is reset.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= bus.rx_dout;
      end
   end

   // NOTE: all state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;   // natural wrap at DEPTH
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         unique case ({wr, rd_fire})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         // Set has priority over clear so a drop is never lost.
         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- self-checking bench for uart_rx_fifo.
//
// A queue holds the bytes the FIFO should contain; each cycle the bench
// applies the acceptance rules to the queue, then compares every DUT
// output against it. Directed sequences cover the listed corner cases,
// followed by a randomized run.

module tb_uart_rx_fifo;

   localparam int DBIT     = 8;
   localparam int ADDR_W   = 4;
   localparam int AF_LEVEL = 12;
   localparam int DEPTH    = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              clr_overrun;
   logic              full;
   logic              almost_full;
   logic [ADDR_W:0]   count;
   logic              overrun;

   uart_rx_fifo_if #(.DBIT(DBIT)) bus ();

   uart_rx_fifo #(
      .DBIT     (DBIT),
      .ADDR_W   (ADDR_W),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus.slave),
      .clr_overrun (clr_overrun),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   // reference state
   logic [DBIT-1:0] q[$];
   logic            m_ovr;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("count",       32'(count),           32'(q.size()));
      check("rd_valid",    32'(bus.rd_valid),    32'(q.size() > 0));
      check("full",        32'(full),            32'(q.size() == DEPTH));
      check("almost_full", 32'(almost_full),     32'(q.size() >= AF_LEVEL));
      check("overrun",     32'(overrun),         32'(m_ovr));
      if (q.size() > 0)
         check("head", 32'(bus.rd_data), 32'(q[0]));
   endtask

   // Apply the current inputs for one clock edge, advancing the model.
   task automatic cycle();
      bit fire;
      bit accept;
      fire   = (q.size() > 0) && bus.rd_ready;
      accept = bus.rx_done_tick && ((q.size() < DEPTH) || fire);
      if (fire) begin
         check("rd_word", 32'(bus.rd_data), 32'(q[0]));
         void'(q.pop_front());
      end
      if (accept) q.push_back(bus.rx_dout);
      if (bus.rx_done_tick && !accept) m_ovr = 1'b1;
      else if (clr_overrun)            m_ovr = 1'b0;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive(input logic tick, input logic [DBIT-1:0] d,
                        input logic rdy, input logic clr);
      bus.rx_done_tick = tick;
      bus.rx_dout      = d;
      bus.rd_ready     = rdy;
      clr_overrun      = clr;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic fill_seq(input int base, input int n);
      for (int i = 0; i < n; i++) drive(1'b1, DBIT'(base + i), 1'b0, 1'b0);
   endtask

   initial begin
      bus.rx_done_tick = 1'b0;
      bus.rx_dout      = '0;
      bus.rd_ready     = 1'b0;
      clr_overrun      = 1'b0;
      m_ovr            = 1'b0;
      reset_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      reset_n = 1'b1;
      idle(1);

      // ready while empty is ignored
      drain(5);

      // single byte, 1-cycle write-to-read latency
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      check("single_head", 32'(bus.rd_data), 32'h0A5);
      drain(1);

      // fill to full (almost_full at 12), drain, then wrap
      fill_seq(8'h00, DEPTH);
      check("fill_full", 32'(full), 32'd1);
      drain(DEPTH);
      fill_seq(8'h10, 5);
      drain(5);

      // overrun on full, clear, set-wins-over-clear
      fill_seq(8'h00, DEPTH);
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      check("ovr_head", 32'(bus.rd_data), 32'h000);
      drive(1'b0, '0, 1'b0, 1'b1);
      drive(1'b1, 8'hEE, 1'b0, 1'b1);
      check("ovr_set_wins", 32'(overrun), 32'd1);
      drive(1'b0, '0, 1'b0, 1'b1);

      // write + read at full: accepted, no overrun, 0x55 comes out last
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      check("full_rw_count", 32'(count), 32'(DEPTH));
      drain(DEPTH - 1);
      check("last_word", 32'(bus.rd_data), 32'h055);
      drain(1);

      // write + read at count==1: rd_valid never drops
      drive(1'b1, 8'h77, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, DBIT'(8'h88 + i), 1'b1, 1'b0);
      drain(1);

      // async reset mid-stream
      for (int i = 0; i < 7; i++) drive(1'b1, DBIT'($urandom), 1'b0, 1'b0);
      bus.rx_done_tick = 1'b0;
      bus.rd_ready     = 1'b0;
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      q.delete();
      m_ovr = 1'b0;
      check("async_count", 32'(count), 32'd0);
      check("async_valid", 32'(bus.rd_valid), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      compare_all();
      drive(1'b1, 8'h3C, 1'b0, 1'b0);
      drain(1);

      // randomized run with shifting write/read pressure
      for (int i = 0; i < 3000; i++) begin
         int phase;
         int p_wr;
         int p_rd;
         phase = (i / 250) % 3;
         p_wr  = (phase == 0) ? 80 : (phase == 1) ? 30 : 55;
         p_rd  = (phase == 0) ? 25 : (phase == 1) ? 80 : 55;
         drive(($urandom_range(99) < p_wr), DBIT'($urandom),
               ($urandom_range(99) < p_rd), ($urandom_range(99) < 5));
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
